// File: rtl/locker_bank_scheduler.sv
// locker_bank_scheduler
//   Arbitrates between the deposit kiosk and the retrieval keypad. It gives each
//   deposit the lowest free locker and binds a PIN to it, and releases a locker when
//   a matching PIN is entered. The chosen door is held open for a timed window.
//   Consecutive bad retrieval PINs are counted, and a timed lockout follows too many.
//   Ports:
//     clk, reset                    clock, synchronous active-low reset
//     dep_req/dep_pin               deposit request (level) and PIN to bind
//     dep_ack/dep_full/dep_locker   deposit response pulses and allocated index
//     ret_req/ret_pin               retrieval request (level) and entered PIN
//     ret_ack/ret_fail/ret_locker   retrieval response pulses and matched index
//     release_all                   maintenance clear of all occupancy (IDLE only)
//     locker_doors                  one-hot door drive
//     occupied                      per-locker occupancy
//     lockout, busy                 status flags
//   All outputs are registered.
module locker_bank_scheduler #(
    parameter int NUM_LOCKERS      = 8,
    parameter int PIN_W            = 4,
    parameter int DOOR_OPEN_CYCLES = 16,
    parameter int MAX_FAILS        = 3,
    parameter int LOCKOUT_CYCLES   = 64,
    localparam int LW              = $clog2(NUM_LOCKERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dep_req,
    input  logic [PIN_W-1:0]       dep_pin,
    output logic                   dep_ack,
    output logic                   dep_full,
    output logic [LW-1:0]          dep_locker,
    input  logic                   ret_req,
    input  logic [PIN_W-1:0]       ret_pin,
    output logic                   ret_ack,
    output logic                   ret_fail,
    output logic [LW-1:0]          ret_locker,
    input  logic                   release_all,
    output logic [NUM_LOCKERS-1:0] locker_doors,
    output logic [NUM_LOCKERS-1:0] occupied,
    output logic                   lockout,
    output logic                   busy
);
    localparam int TMAX = (DOOR_OPEN_CYCLES > LOCKOUT_CYCLES) ? DOOR_OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAILS + 1);

    typedef enum logic [2:0] {S_IDLE, S_DEP, S_RET, S_DOOR, S_LOCK} state_t;

    state_t                             state, next_state;
    logic [NUM_LOCKERS-1:0][PIN_W-1:0]  pins, pins_d;
    logic [NUM_LOCKERS-1:0]             occ_d, doors_d;
    logic [FW-1:0]                      fail_cnt, fail_d, fail_inc;
    logic [CW-1:0]                      cnt, cnt_d;      // shared door / lockout timer
    logic                               rr_last_ret, rr_d; // 1: retrieval won the last tie
    logic                               dep_ack_d, dep_full_d, ret_ack_d, ret_fail_d;
    logic [LW-1:0]                      dep_locker_d, ret_locker_d;
    logic                               lockout_d;
    logic                               free_hit, match_hit;
    logic [LW-1:0]                      free_idx, match_idx;

    // Lowest-index search: scan downward so the last assignment is the lowest hit.
    always_comb begin
        free_hit  = 1'b0;
        free_idx  = '0;
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_LOCKERS - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                free_hit = 1'b1;
                free_idx = LW'(i);
            end
            if (occupied[i] && pins[i] == ret_pin) begin
                match_hit = 1'b1;
                match_idx = LW'(i);
            end
        end
    end

    // Saturating increment of the failure count.
    assign fail_inc = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + FW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (release_all)            next_state = S_IDLE;
                else if (dep_req && ret_req) next_state = rr_last_ret ? S_DEP : S_RET;
                else if (dep_req)            next_state = S_DEP;
                else if (ret_req)            next_state = S_RET;
            end
            S_DEP:  next_state = free_hit ? S_DOOR : S_IDLE;
            S_RET: begin
                if (match_hit)                        next_state = S_DOOR;
                else if (fail_inc == FW'(MAX_FAILS))  next_state = S_LOCK;
                else                                  next_state = S_IDLE;
            end
            S_DOOR: if (cnt == '0) next_state = S_IDLE;
            S_LOCK: if (cnt == '0) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        occ_d        = occupied;
        pins_d       = pins;
        doors_d      = locker_doors;
        fail_d       = fail_cnt;
        rr_d         = rr_last_ret;
        cnt_d        = cnt;
        dep_ack_d    = 1'b0;
        dep_full_d   = 1'b0;
        ret_ack_d    = 1'b0;
        ret_fail_d   = 1'b0;
        dep_locker_d = '0;
        ret_locker_d = '0;
        lockout_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (release_all)             occ_d = '0;
                else if (dep_req && ret_req) rr_d  = (next_state == S_RET);
            end
            S_DEP: begin
                if (free_hit) begin
                    occ_d[free_idx]  = 1'b1;
                    pins_d[free_idx] = dep_pin;
                    dep_ack_d        = 1'b1;
                    dep_locker_d     = free_idx;
                    doors_d          = NUM_LOCKERS'(1) << free_idx;
                    cnt_d            = CW'(DOOR_OPEN_CYCLES - 1);
                end else begin
                    dep_full_d = 1'b1;
                end
            end
            S_RET: begin
                if (match_hit) begin
                    occ_d[match_idx] = 1'b0;
                    ret_ack_d        = 1'b1;
                    ret_locker_d     = match_idx;
                    doors_d          = NUM_LOCKERS'(1) << match_idx;
                    fail_d           = '0;
                    cnt_d            = CW'(DOOR_OPEN_CYCLES - 1);
                end else begin
                    ret_fail_d = 1'b1;
                    fail_d     = fail_inc;
                    if (fail_inc == FW'(MAX_FAILS)) begin
                        lockout_d = 1'b1;
                        cnt_d     = CW'(LOCKOUT_CYCLES - 1);
                    end
                end
            end
            // Timer was loaded with N-1 on the entry edge, so the window spans N cycles.
            S_DOOR: begin
                if (cnt == '0) doors_d = '0;
                else           cnt_d   = cnt - CW'(1);
            end
            S_LOCK: begin
                if (cnt == '0) begin
                    fail_d = '0;
                end else begin
                    cnt_d     = cnt - CW'(1);
                    lockout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            occupied     <= '0;
            pins         <= '0;
            locker_doors <= '0;
            fail_cnt     <= '0;
            rr_last_ret  <= 1'b1;
            cnt          <= '0;
            dep_ack      <= 1'b0;
            dep_full     <= 1'b0;
            ret_ack      <= 1'b0;
            ret_fail     <= 1'b0;
            dep_locker   <= '0;
            ret_locker   <= '0;
            lockout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            occupied     <= occ_d;
            pins         <= pins_d;
            locker_doors <= doors_d;
            fail_cnt     <= fail_d;
            rr_last_ret  <= rr_d;
            cnt          <= cnt_d;
            dep_ack      <= dep_ack_d;
            dep_full     <= dep_full_d;
            ret_ack      <= ret_ack_d;
            ret_fail     <= ret_fail_d;
            dep_locker   <= dep_locker_d;
            ret_locker   <= ret_locker_d;
            lockout      <= lockout_d;
            busy         <= (next_state != S_IDLE);
        end
    end
endmodule

// File: tb/tb_locker_bank_scheduler.sv
module tb_locker_bank_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       dep_req, ret_req, release_all;
    logic [3:0] dep_pin, ret_pin;
    logic       dep_ack, dep_full, ret_ack, ret_fail, lockout, busy;
    logic [2:0] dep_locker, ret_locker;
    logic [7:0] locker_doors, occupied;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    locker_bank_scheduler dut (
        .clk(clk), .reset(reset),
        .dep_req(dep_req), .dep_pin(dep_pin), .dep_ack(dep_ack), .dep_full(dep_full),
        .dep_locker(dep_locker),
        .ret_req(ret_req), .ret_pin(ret_pin), .ret_ack(ret_ack), .ret_fail(ret_fail),
        .ret_locker(ret_locker),
        .release_all(release_all), .locker_doors(locker_doors), .occupied(occupied),
        .lockout(lockout), .busy(busy)
    );

    typedef struct {
        logic       is_ret;
        logic [3:0] pin;
        logic [3:0] exp_resp;   // {dep_ack, dep_full, ret_ack, ret_fail}
        logic [2:0] exp_loc;
        logic [7:0] exp_occ;
    } vec_t;

    vec_t tbl[13];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [3:0] resp_now();
        return {dep_ack, dep_full, ret_ack, ret_fail};
    endfunction

    // Raise the given requests, capture the first response pulse, drop the
    // requests and wait for the FSM to return to IDLE.
    task automatic do_txn(input logic d, input logic r, input logic [3:0] dp, input logic [3:0] rp,
                          output logic [3:0] resp, output logic [2:0] loc, output logic [7:0] drs);
        dep_req = d; ret_req = r; dep_pin = dp; ret_pin = rp;
        resp = '0; loc = '0; drs = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resp_now() != 4'b0) begin
                resp = resp_now();
                loc  = dep_locker | ret_locker;
                drs  = locker_doors;
                break;
            end
        end
        dep_req = 1'b0; ret_req = 1'b0;
        chk("resp_seen", {31'b0, resp != 4'b0}, 32'd1);
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("back_to_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [3:0] rs;
        logic [2:0] lc;
        logic [7:0] dr, exp_dr;
        int n, bad;

        tbl[0]  = '{1'b0, 4'h1, 4'b1000, 3'd1, 8'h03};
        tbl[1]  = '{1'b0, 4'h3, 4'b1000, 3'd2, 8'h07};
        tbl[2]  = '{1'b0, 4'h4, 4'b1000, 3'd3, 8'h0F};
        tbl[3]  = '{1'b0, 4'h5, 4'b1000, 3'd4, 8'h1F};
        tbl[4]  = '{1'b0, 4'h3, 4'b1000, 3'd5, 8'h3F};
        tbl[5]  = '{1'b0, 4'h6, 4'b1000, 3'd6, 8'h7F};
        tbl[6]  = '{1'b0, 4'h7, 4'b1000, 3'd7, 8'hFF};
        tbl[7]  = '{1'b0, 4'h8, 4'b0100, 3'd0, 8'hFF};  // bank full
        tbl[8]  = '{1'b1, 4'h3, 4'b0010, 3'd2, 8'hFB};  // duplicate PIN: lowest wins
        tbl[9]  = '{1'b1, 4'h3, 4'b0010, 3'd5, 8'hDB};
        tbl[10] = '{1'b1, 4'h3, 4'b0001, 3'd0, 8'hDB};  // no occupied match
        tbl[11] = '{1'b1, 4'hA, 4'b0010, 3'd0, 8'hDA};
        tbl[12] = '{1'b0, 4'h9, 4'b1000, 3'd0, 8'hDB};

        reset = 1'b0; dep_req = 1'b0; ret_req = 1'b0; release_all = 1'b0;
        dep_pin = '0; ret_pin = '0;
        @(negedge clk);
        tick(); tick();
        chk("rst_doors", {24'b0, locker_doors}, 32'h0);
        chk("rst_occ", {24'b0, occupied}, 32'h0);
        chk("rst_flags", {26'b0, resp_now(), lockout, busy}, 32'h0);
        reset = 1'b1;
        tick();

        // T1: first deposit, exact latency and door window
        dep_req = 1'b1; dep_pin = 4'hA;
        tick();
        chk("t1_no_early_ack", {31'b0, dep_ack}, 32'd0);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("t1_resp", {28'b0, resp_now()}, 32'b1000);
        chk("t1_loc", {29'b0, dep_locker}, 32'd0);
        chk("t1_occ", {24'b0, occupied}, 32'h01);
        dep_req = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && locker_doors == 8'h01; i++) begin
            n++;
            tick();
            if (n == 1) chk("t1_pulse_1cyc", {28'b0, resp_now()}, 32'h0);
        end
        chk("t1_door_cycles", n, 32'd16);
        chk("t1_doors_closed", {24'b0, locker_doors}, 32'h0);
        chk("t1_idle", {31'b0, busy}, 32'd0);

        // T2 / T4: table-driven fill, full, duplicate-PIN retrieval, misses
        for (int k = 0; k < 13; k++) begin
            do_txn(!tbl[k].is_ret, tbl[k].is_ret, tbl[k].pin, tbl[k].pin, rs, lc, dr);
            exp_dr = (tbl[k].exp_resp[3] | tbl[k].exp_resp[1]) ? (8'h01 << tbl[k].exp_loc) : 8'h00;
            chk($sformatf("v%0d_resp", k), {28'b0, rs}, {28'b0, tbl[k].exp_resp});
            chk($sformatf("v%0d_loc", k), {29'b0, lc}, {29'b0, tbl[k].exp_loc});
            chk($sformatf("v%0d_doors", k), {24'b0, dr}, {24'b0, exp_dr});
            chk($sformatf("v%0d_occ", k), {24'b0, occupied}, {24'b0, tbl[k].exp_occ});
        end

        // T3: simultaneous requests alternate, deposit first
        do_txn(1'b1, 1'b1, 4'hB, 4'h1, rs, lc, dr);
        chk("t3_r1", {25'b0, rs, lc}, {25'b0, 4'b1000, 3'd2});
        do_txn(1'b1, 1'b1, 4'hB, 4'h1, rs, lc, dr);
        chk("t3_r2", {25'b0, rs, lc}, {25'b0, 4'b0010, 3'd1});
        do_txn(1'b1, 1'b1, 4'hC, 4'h1, rs, lc, dr);
        chk("t3_r3", {25'b0, rs, lc}, {25'b0, 4'b1000, 3'd1});
        chk("t3_occ", {24'b0, occupied}, 32'hDF);

        // T5: three bad PINs -> lockout, requests ignored throughout
        do_txn(1'b0, 1'b1, 4'h0, 4'hE, rs, lc, dr);
        chk("t5_f1", {28'b0, rs}, 32'b0001);
        do_txn(1'b0, 1'b1, 4'h0, 4'hE, rs, lc, dr);
        chk("t5_f2", {28'b0, rs}, 32'b0001);
        chk("t5_no_lock_yet", {31'b0, lockout}, 32'd0);
        ret_req = 1'b1; ret_pin = 4'hE;
        tick(); tick();
        chk("t5_f3", {28'b0, resp_now()}, 32'b0001);
        chk("t5_lock_on", {31'b0, lockout}, 32'd1);
        dep_req = 1'b1; dep_pin = 4'hD; ret_pin = 4'h4; release_all = 1'b1;
        n = 0; bad = 0;
        for (int i = 0; i < 200 && lockout; i++) begin
            n++;
            if (resp_now() != 4'b0001 && i == 0) bad++;
            if (resp_now() != 4'b0 && i > 0) bad++;
            if (locker_doors != 8'h0) bad++;
            tick();
        end
        dep_req = 1'b0; release_all = 1'b0;
        chk("t5_lock_cycles", n, 32'd64);
        chk("t5_ignored", bad, 32'd0);
        chk("t5_occ_kept", {24'b0, occupied}, 32'hDF);
        rs = '0; lc = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resp_now() != 4'b0) begin
                rs = resp_now(); lc = ret_locker; break;
            end
        end
        ret_req = 1'b0;
        chk("t5_ret_after", {25'b0, rs, lc}, {25'b0, 4'b0010, 3'd3});
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("t5_idle", {31'b0, busy}, 32'd0);

        // release_all in IDLE wins over a pending deposit for that cycle
        release_all = 1'b1; dep_req = 1'b1; dep_pin = 4'h2;
        tick();
        chk("rel_occ", {24'b0, occupied}, 32'h0);
        chk("rel_ignored", {31'b0, busy}, 32'd0);
        release_all = 1'b0;
        tick(); tick();
        chk("rel_dep", {25'b0, resp_now(), dep_locker}, {25'b0, 4'b1000, 3'd0});
        dep_req = 1'b0;

        // T6: reset in the middle of a door window
        for (int i = 0; i < 5; i++) tick();
        chk("t6_door_open", {24'b0, locker_doors}, 32'h01);
        reset = 1'b0;
        tick();
        chk("t6_doors", {24'b0, locker_doors}, 32'h0);
        chk("t6_occ", {24'b0, occupied}, 32'h0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        tick();
        do_txn(1'b1, 1'b0, 4'h2, 4'h0, rs, lc, dr);
        chk("t6_dep", {25'b0, rs, lc}, {25'b0, 4'b1000, 3'd0});
        chk("t6_occ_after", {24'b0, occupied}, 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
